prime_picker: RTL and testbench

Downstream consumer of the 7-bit LFSR random source in the public-key decryption datapath. Samples the free-running random word on request and rejects candidates until one is prime, using sequential trial division by repeated subtraction. The prime is then offered to key-setup logic over a valid/ready handshake.

---
 rtl/prime_picker_pkg.sv | 13 +
 rtl/prime_picker_if.sv | 16 +
 rtl/prime_trial_div.sv | 54 +++++
 rtl/prime_picker.sv | 134 +++++++++++++
 tb/tb_prime_picker.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/prime_picker_pkg.sv
// Shared types and constants for prime_picker and its trial-division datapath.
package prime_picker_pkg;

   typedef enum logic [1:0] {IDLE, SCREEN, MOD, DONE} state_e;

   localparam int unsigned ATTEMPT_W = 8;
   localparam logic [ATTEMPT_W-1:0] ATTEMPT_MAX = 8'd255;

   function automatic logic [ATTEMPT_W-1:0] sat_inc(input logic [ATTEMPT_W-1:0] a);
      return (a == ATTEMPT_MAX) ? a : a + 8'd1;
   endfunction

endpackage

// File: rtl/prime_picker_if.sv
// Request/offer handshake between prime_picker and the key-setup consumer.
interface prime_picker_if #(parameter int unsigned W = 7);
   import prime_picker_pkg::*;

   logic                 start;
   logic                 busy;
   logic [W-1:0]         prime_out;
   logic                 prime_valid;
   logic                 prime_ready;
   logic [ATTEMPT_W-1:0] attempts;

   modport master (output start, prime_ready,
                   input  busy, prime_out, prime_valid, attempts);
   modport slave  (input  start, prime_ready,
                   output busy, prime_out, prime_valid, attempts);
endinterface

// File: rtl/prime_trial_div.sv
// Trial divisor d and running remainder r; one subtraction or divisor step per cycle.
module prime_trial_div #(
   parameter int unsigned W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] cand,
   input  logic         load,
   input  logic         step,
   output logic         divisible,
   output logic         exhausted,
   output logic         in_progress
);

   logic [W-1:0]   d_q, d_d;
   logic [W-1:0]   r_q, r_d;
   logic [2*W-1:0] d_plus2;
   logic [2*W-1:0] d_plus2_sq;

   always_comb begin
      d_plus2     = {{W{1'b0}}, d_q} + (2*W)'(2);
      d_plus2_sq  = d_plus2 * d_plus2;
      in_progress = (r_q >= d_q);
      divisible   = (r_q == '0) && !in_progress;
      exhausted   = (d_plus2_sq > {{W{1'b0}}, cand});
   end

   always_comb begin
      d_d = d_q;
      r_d = r_q;
      if (load) begin
         d_d = W'(3);
         r_d = cand;
      end else if (step) begin
         if (in_progress) begin
            r_d = r_q - d_q;
         end else begin
            d_d = d_q + W'(2);
            r_d = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= '0;
         r_q <= '0;
      end else begin
         d_q <= d_d;
         r_q <= r_d;
      end
   end

endmodule

// File: rtl/prime_picker.sv
// Samples the RNG word, rejects until prime, offers the prime over valid/ready.
// PRIME_PICKER_DISTINCT_EN: reject a prime equal to the previously delivered one.
module prime_picker
   import prime_picker_pkg::*;
#(
   parameter int unsigned W = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   rand_in,
   prime_picker_if.slave  bus
);

   state_e               state_q, state_d;
   logic [W-1:0]         cand_q, cand_d;
   logic [W-1:0]         prime_out_q, prime_out_d;
   logic                 prime_valid_q, prime_valid_d;
   logic [ATTEMPT_W-1:0] attempts_q, attempts_d;
`ifdef PRIME_PICKER_DISTINCT_EN
   logic [W-1:0]         last_prime_q, last_prime_d;
`endif

   logic load, step, divisible, exhausted, in_progress;
   logic declare, accept, resample;

   prime_trial_div #(.W(W)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .cand        (cand_q),
      .load        (load),
      .step        (step),
      .divisible   (divisible),
      .exhausted   (exhausted),
      .in_progress (in_progress)
   );

   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      prime_out_d   = prime_out_q;
      prime_valid_d = prime_valid_q;
      attempts_d    = attempts_q;
`ifdef PRIME_PICKER_DISTINCT_EN
      last_prime_d  = last_prime_q;
`endif
      load     = 1'b0;
      step     = 1'b0;
      declare  = 1'b0;
      accept   = 1'b0;
      resample = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cand_d     = rand_in;
               attempts_d = 8'd1;
               state_d    = SCREEN;
            end
         end
         SCREEN: begin
            if (cand_q < W'(2))                          resample = 1'b1;
            else if (cand_q == W'(2) || cand_q == W'(3)) declare  = 1'b1;
            else if (!cand_q[0])                         resample = 1'b1;
            else begin
               load    = 1'b1;
               state_d = MOD;
            end
         end
         MOD: begin
            if (in_progress)    step     = 1'b1;
            else if (divisible) resample = 1'b1;
            else if (exhausted) declare  = 1'b1;
            else                step     = 1'b1;
         end
         DONE: begin
            if (prime_valid_q && bus.prime_ready) begin
               prime_valid_d = 1'b0;
               state_d       = IDLE;
`ifdef PRIME_PICKER_DISTINCT_EN
               last_prime_d  = prime_out_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A repeat of the last delivered prime is handled exactly like a composite.
`ifdef PRIME_PICKER_DISTINCT_EN
      if (declare && cand_q == last_prime_q) resample = 1'b1;
      else                                   accept   = declare;
`else
      accept = declare;
`endif

      if (accept) begin
         prime_out_d   = cand_q;
         prime_valid_d = 1'b1;
         state_d       = DONE;
      end
      if (resample) begin
         cand_d     = rand_in;
         attempts_d = sat_inc(attempts_q);
         state_d    = SCREEN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cand_q        <= '0;
         prime_out_q   <= '0;
         prime_valid_q <= 1'b0;
         attempts_q    <= '0;
`ifdef PRIME_PICKER_DISTINCT_EN
         last_prime_q  <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         prime_out_q   <= prime_out_d;
         prime_valid_q <= prime_valid_d;
         attempts_q    <= attempts_d;
`ifdef PRIME_PICKER_DISTINCT_EN
         last_prime_q  <= last_prime_d;
`endif
      end
   end

   assign bus.busy        = (state_q == SCREEN) || (state_q == MOD);
   assign bus.prime_out   = prime_out_q;
   assign bus.prime_valid = prime_valid_q;
   assign bus.attempts    = attempts_q;

endmodule

// File: tb/tb_prime_picker.sv
// Self-checking bench for prime_picker: directed table, corner sequences, randomized jobs.
module tb_prime_picker;

   localparam int unsigned W  = 7;
   localparam int          NR = 4096;
`ifdef PRIME_PICKER_DISTINCT_EN
   localparam bit DISTINCT = 1'b1;
`else
   localparam bit DISTINCT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] rand_in = '0;

   prime_picker_if #(.W(W)) bus ();

   prime_picker #(.W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rand_in (rand_in),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] rnd [NR];
   logic [W-1:0] last_exp = '0;

   typedef struct {
      logic [W-1:0] r0, r1, r2, r3;
      int           lat;
      logic [W-1:0] p;
      logic [7:0]   att;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: cycle cost from the trial-division rules, not from the RTL state machine.
   function automatic int model_job(input logic [W-1:0] last, output logic [W-1:0] p,
                                    output logic [7:0] att);
      int t = 0;
      int c = int'(rnd[0]);
      bit prime;
      att = 8'd1;
      p   = '0;
      while (t < NR - 1) begin
         prime = 1'b0;
         if (c == 2 || c == 3) begin
            t += 1;
            prime = 1'b1;
         end else if (c < 2 || c % 2 == 0) begin
            t += 1;
         end else begin
            t += 1;
            for (int d = 3; d < c; d += 2) begin
               t += c / d + 1;
               if (c % d == 0) break;
               if ((d + 2) * (d + 2) > c) begin
                  prime = 1'b1;
                  break;
               end
            end
         end
         if (DISTINCT && prime && c == int'(last)) prime = 1'b0;
         if (prime) begin
            p = W'(c);
            return t;
         end
         if (t >= NR) break;
         c   = int'(rnd[t]);
         att = (att == 8'd255) ? att : att + 8'd1;
      end
      return -1;
   endfunction

   // Entered just after a clock edge with the DUT idle; returns edges until prime_valid.
   task automatic run_job(input string name, output int lat);
      lat = -1;
      bus.start = 1'b1;
      rand_in   = rnd[0];
      for (int j = 0; j < NR - 1; j++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         rand_in   = rnd[j + 1];
         if (j == 0 && !bus.prime_valid) chk({name, " busy"}, 32'(bus.busy), 32'd1);
         if (bus.prime_valid) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic handshake(input string name);
      bus.prime_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.prime_ready = 1'b0;
      chk({name, " valid_drop"}, 32'(bus.prime_valid), 32'd0);
      chk({name, " idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic apply(input string name, input int exp_lat, input logic [W-1:0] exp_p,
                        input logic [7:0] exp_att);
      int lat;
      run_job(name, lat);
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " prime"}, 32'(bus.prime_out), 32'(exp_p));
      chk({name, " attempts"}, 32'(bus.attempts), 32'(exp_att));
      handshake(name);
      last_exp = exp_p;
   endtask

   task automatic apply_model(input string name);
      int           lat;
      logic [W-1:0] p;
      logic [7:0]   att;
      lat = model_job(last_exp, p, att);
      apply(name, lat, p, att);
   endtask

   initial begin
      int lat;
      bus.start       = 1'b0;
      bus.prime_ready = 1'b0;

      tbl[0] = '{r0: 7,   r1: 7,  r2: 7,  r3: 7,  lat: 4,   p: 7,   att: 1};
      tbl[1] = '{r0: 9,   r1: 11, r2: 11, r3: 11, lat: 10,  p: 11,  att: 2};
      tbl[2] = '{r0: 0,   r1: 1,  r2: 4,  r3: 2,  lat: 4,   p: 2,   att: 4};
      tbl[3] = '{r0: 3,   r1: 3,  r2: 3,  r3: 3,  lat: 1,   p: 3,   att: 1};
      tbl[4] = '{r0: 127, r1: 0,  r2: 0,  r3: 0,  lat: 116, p: 127, att: 1};
      tbl[5] = '{r0: 4,   r1: 4,  r2: 4,  r3: 5,  lat: 6,   p: 5,   att: 4};
`ifdef PRIME_PICKER_DISTINCT_EN
      tbl[6] = '{r0: 5,   r1: 5,  r2: 5,  r3: 13, lat: 9,   p: 13,  att: 2};
`else
      tbl[6] = '{r0: 5,   r1: 5,  r2: 5,  r3: 13, lat: 3,   p: 5,   att: 1};
`endif

      // Reset with start pulsing: nothing may leave the reset values.
      for (int i = 0; i < 4; i++) begin
         bus.start = i[0];
         rand_in   = W'(3);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset valid", 32'(bus.prime_valid), 32'd0);
      chk("reset prime", 32'(bus.prime_out), 32'd0);
      chk("reset attempts", 32'(bus.attempts), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < NR; k++)
            rnd[k] = (k == 0) ? tbl[i].r0 : (k == 1) ? tbl[i].r1 :
                     (k == 2) ? tbl[i].r2 : tbl[i].r3;
         apply($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].p, tbl[i].att);
      end

      // Backpressure: valid and data held, start ignored in DONE and at the handshake.
      for (int k = 0; k < NR; k++) rnd[k] = W'(11);
      run_job("bp", lat);
      chk("bp latency", 32'(lat), 32'd5);
      for (int i = 0; i < 10; i++) begin
         bus.start = i[0];
         @(posedge clk);
         #1;
         chk("bp valid_hold", 32'(bus.prime_valid), 32'd1);
         chk("bp prime_hold", 32'(bus.prime_out), 32'd11);
      end
      bus.start       = 1'b1;
      bus.prime_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.start       = 1'b0;
      bus.prime_ready = 1'b0;
      chk("bp valid_drop", 32'(bus.prime_valid), 32'd0);
      chk("bp idle_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      chk("bp start_ignored", 32'(bus.busy), 32'd0);
      chk("bp prime_after", 32'(bus.prime_out), 32'd11);
      last_exp = W'(11);

      // Asynchronous reset mid-job, then the same prime must be accepted again.
      for (int k = 0; k < NR; k++) rnd[k] = W'(127);
      bus.start = 1'b1;
      rand_in   = rnd[0];
      repeat (10) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      chk("midrst busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst attempts", 32'(bus.attempts), 32'd0);
      chk("midrst prime", 32'(bus.prime_out), 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      last_exp = '0;
      for (int k = 0; k < NR; k++) rnd[k] = W'(11);
      apply("after_rst", 5, W'(11), 8'd1);

      // Stuck zero source: attempts must saturate.
      for (int k = 0; k < NR; k++) rnd[k] = (k < 300) ? '0 : (k == 300) ? W'(3) : W'(2);
      apply_model("saturate");
      chk("saturate value", 32'(bus.attempts), 32'd255);

      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < NR; k++) rnd[k] = W'($urandom_range(0, 127));
         apply_model($sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
